// File: rtl/ava_pcm.sv
// Audio sample FIFO feeding a divider-paced PWM playback stage.
// Latency: accepted write visible in level/wr_full/pcm_empty next cycle; tick pop updates cur_sample next cycle; pwm_o lags by one.
// Backpressure: wr_full blocks writes (dropped silently); an empty tick holds the last sample and pulses underrun.
module ava_pcm #(
  parameter int FIFO_DEPTH   = 16,
  parameter int SAMPLE_DIV   = 2268,
  parameter int SAMPLE_WIDTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          wr_en,
  input  logic [SAMPLE_WIDTH-1:0]       wr_data,
  output logic                          wr_full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  input  logic                          enable,
  output logic                          pcm_empty,
  output logic                          underrun,
  output logic                          pwm_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam logic [SAMPLE_WIDTH-1:0] MIDSCALE = SAMPLE_WIDTH'(1) << (SAMPLE_WIDTH - 1);

  logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_ptr;
  logic [DW-1:0]           div_cnt;
  logic [SAMPLE_WIDTH-1:0] pwm_cnt;
  logic [SAMPLE_WIDTH-1:0] cur_sample;
  logic                    tick;
  logic                    wr_accept;
  logic                    pop;

  // Status flags come only from the registered occupancy count.
  assign wr_full   = (level == LW'(FIFO_DEPTH));
  assign pcm_empty = (level == '0);

  // Acceptance and pop both use pre-update state, so a write into an empty
  // FIFO on a tick cannot be popped in the same cycle.
  assign wr_accept = wr_en & ~wr_full;
  assign tick      = enable & (div_cnt == DW'(SAMPLE_DIV - 1));
  assign pop       = tick & ~pcm_empty;

  // Sample storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; a simultaneous write and pop leaves level unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)       rd_ptr <= rd_ptr + PW'(1);
      case ({wr_accept, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Sample-period divider, parked at zero while playback is disabled.
  always_ff @(posedge clk_i) begin
    if (rst_i || !enable) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Current sample register and underrun pulse on an empty tick.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_sample <= MIDSCALE;
      underrun   <= 1'b0;
    end else begin
      if (pop) cur_sample <= mem[rd_ptr];
      underrun <= tick & pcm_empty;
    end
  end

  // Free-running PWM counter and registered comparator output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwm_cnt <= '0;
      pwm_o   <= 1'b0;
    end else begin
      pwm_cnt <= enable ? pwm_cnt + SAMPLE_WIDTH'(1) : '0;
      pwm_o   <= enable & (pwm_cnt < cur_sample);
    end
  end

endmodule

// File: tb/tb_ava_pcm.sv
// Directed bench for ava_pcm with a 4-deep FIFO and a 4-clock sample period.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Internal cur_sample/div_cnt are observed hierarchically where no port exists.
module tb_ava_pcm;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_full;
  logic [2:0] level;
  logic       enable;
  logic       pcm_empty;
  logic       underrun;
  logic       pwm_o;

  int tests = 0;
  int fails = 0;
  int hi_cnt;

  ava_pcm #(.FIFO_DEPTH(4), .SAMPLE_DIV(4), .SAMPLE_WIDTH(8)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_full  (wr_full),
    .level    (level),
    .enable   (enable),
    .pcm_empty(pcm_empty),
    .underrun (underrun),
    .pwm_o    (pwm_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b1; wr_en = 1'b0; wr_data = 8'h00; enable = 1'b0;
    step(2);
    rst_i = 1'b0;
    check("rst_pcm_empty", 32'(pcm_empty), 1);
    check("rst_level", 32'(level), 0);
    check("rst_wr_full", 32'(wr_full), 0);
    check("rst_pwm_o", 32'(pwm_o), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_cur_sample", 32'(dut.cur_sample), 32'h80);

    // Fill while disabled; fifth write must be dropped.
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'((i + 1) * 16);
      step(1);
      check($sformatf("fill_level_%0d", i), 32'(level), (i < 4) ? i + 1 : 4);
      check($sformatf("fill_full_%0d", i), 32'(wr_full), (i >= 3) ? 1 : 0);
    end
    wr_en = 1'b0;
    check("fill_not_empty", 32'(pcm_empty), 0);
    check("disabled_cur_held", 32'(dut.cur_sample), 32'h80);

    // Drain: first tick 3 cycles after enable, pop visible one cycle later.
    enable = 1'b1;
    step(3);
    check("first_tick_div", 32'(dut.div_cnt), 3);
    step(1);
    check("drain_0", 32'(dut.cur_sample), 32'h10);
    check("drain_level_0", 32'(level), 3);
    step(4);
    check("drain_1", 32'(dut.cur_sample), 32'h20);
    step(4);
    check("drain_2", 32'(dut.cur_sample), 32'h30);
    step(3);
    check("pre_last_pop_empty", 32'(pcm_empty), 0);
    step(1);
    check("drain_3", 32'(dut.cur_sample), 32'h40);
    check("drain_empty", 32'(pcm_empty), 1);
    check("drain_no_underrun", 32'(underrun), 0);
    step(4);
    check("underrun_pulse", 32'(underrun), 1);
    check("underrun_cur_held", 32'(dut.cur_sample), 32'h40);
    step(1);
    check("underrun_one_cycle", 32'(underrun), 0);

    // div_cnt is now 1. Queue 0x55, then write 0x66 on the popping tick.
    wr_en = 1'b1; wr_data = 8'h55;
    step(1);
    wr_en = 1'b0;
    step(1);
    check("simul_pre_level", 32'(level), 1);
    wr_en = 1'b1; wr_data = 8'h66;
    step(1);
    wr_en = 1'b0;
    check("simul_level", 32'(level), 1);
    check("simul_cur", 32'(dut.cur_sample), 32'h55);
    step(4);
    check("simul_order", 32'(dut.cur_sample), 32'h66);
    check("simul_level_after", 32'(level), 0);

    // Write into empty FIFO on a tick cycle (div_cnt 0 -> wait to 3).
    step(3);
    check("wtick_div", 32'(dut.div_cnt), 3);
    wr_en = 1'b1; wr_data = 8'h77;
    step(1);
    wr_en = 1'b0;
    check("wtick_underrun", 32'(underrun), 1);
    check("wtick_level", 32'(level), 1);
    check("wtick_cur_held", 32'(dut.cur_sample), 32'h66);

    // PWM duty for 0x40: restart cleanly, queue 0x40 and let it pop.
    rst_i = 1'b1; enable = 1'b0;
    step(1);
    rst_i = 1'b0;
    wr_en = 1'b1; wr_data = 8'h40;
    step(1);
    wr_en = 1'b0; enable = 1'b1;
    step(4);
    check("pwm40_cur", 32'(dut.cur_sample), 32'h40);
    step(1);
    hi_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      step(1);
      hi_cnt += int'(pwm_o);
    end
    check("pwm_duty_40", 32'(hi_cnt), 64);

    // Disabling keeps cur_sample and forces pwm_o low.
    enable = 1'b0;
    step(2);
    check("disable_cur_held", 32'(dut.cur_sample), 32'h40);
    check("disable_pwm_low", 32'(pwm_o), 0);
    enable = 1'b1;

    // PWM duty for 0x00.
    wr_en = 1'b1; wr_data = 8'h00;
    step(1);
    wr_en = 1'b0;
    step(6);
    check("pwm00_cur", 32'(dut.cur_sample), 0);
    hi_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      step(1);
      hi_cnt += int'(pwm_o);
    end
    check("pwm_duty_00", 32'(hi_cnt), 0);

    // Reset mid-playback with three samples queued and ticks running.
    enable = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'(8'hA0 + i);
      step(1);
    end
    wr_en = 1'b0; enable = 1'b1;
    step(2);
    check("mid_level_3", 32'(level), 3);
    rst_i = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    step(1);
    rst_i = 1'b0; wr_en = 1'b0;
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_empty", 32'(pcm_empty), 1);
    check("mid_rst_cur", 32'(dut.cur_sample), 32'h80);
    check("mid_rst_div", 32'(dut.div_cnt), 0);
    check("mid_rst_pwm", 32'(pwm_o), 0);
    step(1);
    check("mid_rst_div_restart", 32'(dut.div_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
